// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC handshake, instruction-memory port and decode queue head.
// master = fetch unit side, slave = surrounding pipeline/memory side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] PcAddress;
  logic              PcAdvance;
  logic              Flush;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemReq;
  logic              MemAck;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] InstrOut;
  logic [ADDR_W-1:0] InstrPc;
  logic              InstrValid;
  logic              DecodeReady;

  modport master (
    input  PcAddress, Flush, MemAck, MemData, DecodeReady,
    output PcAdvance, MemAddr, MemReq, InstrOut, InstrPc, InstrValid
  );

  modport slave (
    output PcAddress, Flush, MemAck, MemData, DecodeReady,
    input  PcAdvance, MemAddr, MemReq, InstrOut, InstrPc, InstrValid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher feeding a 2-entry {pc, instr} queue; ack-to-valid is one edge.
// New fetches stall while the queue is full or a request is in flight; Flush empties the queue.
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]        state;
  logic [1:0]        count;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              advance;
  logic              push;
  logic              pop;

  assign advance = (state == IDLE) && (count < 2'd2) && !bus.Flush && reset;
  assign push    = (state == WAIT) && bus.MemAck && !bus.Flush;
  assign pop     = (count != 2'd0) && bus.DecodeReady;

  assign bus.PcAdvance  = advance;
  assign bus.MemAddr    = mem_addr;
  assign bus.MemReq     = mem_req;
  assign bus.InstrOut   = data0;
  assign bus.InstrPc    = addr0;
  assign bus.InstrValid = (count != 2'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (advance) begin
            mem_addr <= bus.PcAddress;
            mem_req  <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // An ack always closes the request; Flush only decides whether its data is kept.
          if (bus.MemAck) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (bus.Flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (bus.MemAck) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Entry 0 is always the head; pops shift entry 1 down.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= 2'd0;
      addr0 <= '0;
      addr1 <= '0;
      data0 <= '0;
      data1 <= '0;
    end else if (bus.Flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            addr0 <= mem_addr;
            data0 <= bus.MemData;
          end else begin
            addr1 <= mem_addr;
            data1 <= bus.MemData;
          end
        end
        2'b01: begin
          addr0 <= addr1;
          data0 <= data1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            addr0 <= mem_addr;
            data0 <= bus.MemData;
          end else begin
            addr0 <= addr1;
            data0 <= data1;
            addr1 <= mem_addr;
            data1 <= bus.MemData;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_instr_fetch_unit;
  logic clock;
  logic reset;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass;
  int n_total;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [15:0] pc;
    logic        ack;
    logic [31:0] md;
    logic        dr;
    logic        e_adv;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_vld;
    logic [15:0] e_ipc;
    logic [31:0] e_ins;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  localparam logic [31:0] D40  = 32'hA000_0040;
  localparam logic [31:0] D88  = 32'hB000_0088;
  localparam logic [31:0] D100 = 32'hC000_0100;
  localparam logic [31:0] D333 = 32'hD000_0333;
  localparam logic [31:0] D200 = 32'hE000_0200;

  vec_t tbl [10];

  // reference model state
  ent_t        mq [$];
  bit          m_out;
  bit          m_drop;
  logic [15:0] m_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic apply(input logic rst, input logic fl, input logic [15:0] pc,
                       input logic ack, input logic [31:0] md, input logic dr);
    reset           = rst;
    bus.Flush       = fl;
    bus.PcAddress   = pc;
    bus.MemAck      = ack;
    bus.MemData     = md;
    bus.DecodeReady = dr;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
    step();
    step();
  endtask

  task automatic fetch(input logic [15:0] a, input logic [31:0] d, input logic dr);
    apply(1'b1, 1'b0, a, 1'b0, 32'd0, dr);
    step();
    apply(1'b1, 1'b0, a, 1'b1, d, dr);
    step();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    apply(1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);

    //            rst fl  pc      ack md    dr   adv req addr    vld ipc     ins
    tbl[0] = '{1'b0, 1'b0, 16'd0,   1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 16'd0,   32'd0};
    tbl[1] = '{1'b0, 1'b0, 16'd40,  1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 16'd0,   32'd0};
    tbl[2] = '{1'b1, 1'b0, 16'd40,  1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 16'd40,  1'b0, 16'd0,   32'd0};
    tbl[3] = '{1'b1, 1'b0, 16'd40,  1'b1, D40,   1'b0, 1'b0, 1'b0, 16'd40,  1'b1, 16'd40,  D40};
    tbl[4] = '{1'b1, 1'b0, 16'd88,  1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 16'd88,  1'b1, 16'd40,  D40};
    tbl[5] = '{1'b1, 1'b0, 16'd88,  1'b1, D88,   1'b0, 1'b0, 1'b0, 16'd88,  1'b1, 16'd40,  D40};
    tbl[6] = '{1'b1, 1'b0, 16'd100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd88,  1'b1, 16'd40,  D40};
    tbl[7] = '{1'b1, 1'b0, 16'd100, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd88,  1'b1, 16'd88,  D88};
    tbl[8] = '{1'b1, 1'b0, 16'd100, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 16'd100, 1'b0, 16'd0,   32'd0};
    tbl[9] = '{1'b1, 1'b0, 16'd100, 1'b1, D100,  1'b0, 1'b0, 1'b0, 16'd100, 1'b1, 16'd100, D100};

    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].rst, tbl[i].fl, tbl[i].pc, tbl[i].ack, tbl[i].md, tbl[i].dr);
      #1;
      check($sformatf("vec%0d_adv", i), 64'(bus.PcAdvance), 64'(tbl[i].e_adv));
      step();
      check($sformatf("vec%0d_req", i), 64'(bus.MemReq), 64'(tbl[i].e_req));
      check($sformatf("vec%0d_addr", i), 64'(bus.MemAddr), 64'(tbl[i].e_addr));
      check($sformatf("vec%0d_vld", i), 64'(bus.InstrValid), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld || !tbl[i].rst) begin
        check($sformatf("vec%0d_ipc", i), 64'(bus.InstrPc), 64'(tbl[i].e_ipc));
        check($sformatf("vec%0d_ins", i), 64'(bus.InstrOut), 64'(tbl[i].e_ins));
      end
    end

    // Flush while waiting, extra Flush in DROP, late ack discarded, refetch from new PC
    do_reset();
    apply(1'b1, 1'b0, 16'd666, 1'b0, 32'd0, 1'b0);
    step();
    check("flw_req", 64'(bus.MemReq), 64'd1);
    check("flw_addr", 64'(bus.MemAddr), 64'd666);
    apply(1'b1, 1'b1, 16'd333, 1'b0, 32'd0, 1'b0);
    #1 check("flw_adv_flush", 64'(bus.PcAdvance), 64'd0);
    step();
    check("flw_req_hold", 64'(bus.MemReq), 64'd1);
    check("flw_addr_hold", 64'(bus.MemAddr), 64'd666);
    apply(1'b1, 1'b0, 16'd333, 1'b0, 32'd0, 1'b0);
    #1 check("flw_adv_drop", 64'(bus.PcAdvance), 64'd0);
    step();
    apply(1'b1, 1'b1, 16'd333, 1'b0, 32'd0, 1'b0);
    step();
    apply(1'b1, 1'b0, 16'd333, 1'b1, 32'hDEAD_0666, 1'b0);
    step();
    check("flw_req_clr", 64'(bus.MemReq), 64'd0);
    check("flw_vld", 64'(bus.InstrValid), 64'd0);
    apply(1'b1, 1'b0, 16'd333, 1'b0, 32'd0, 1'b0);
    #1 check("flw_adv_idle", 64'(bus.PcAdvance), 64'd1);
    step();
    check("flw_new_addr", 64'(bus.MemAddr), 64'd333);
    apply(1'b1, 1'b0, 16'd333, 1'b1, D333, 1'b0);
    step();
    check("flw_new_vld", 64'(bus.InstrValid), 64'd1);
    check("flw_new_pc", 64'(bus.InstrPc), 64'd333);
    check("flw_new_ins", 64'(bus.InstrOut), 64'(D333));

    // Push and pop together with one entry queued
    do_reset();
    fetch(16'd40, D40, 1'b0);
    apply(1'b1, 1'b0, 16'd88, 1'b0, 32'd0, 1'b0);
    step();
    apply(1'b1, 1'b0, 16'd88, 1'b1, D88, 1'b1);
    step();
    check("pp_vld", 64'(bus.InstrValid), 64'd1);
    check("pp_pc", 64'(bus.InstrPc), 64'd88);
    check("pp_ins", 64'(bus.InstrOut), 64'(D88));
    apply(1'b1, 1'b0, 16'd88, 1'b0, 32'd0, 1'b1);
    step();
    check("pp_count1", 64'(bus.InstrValid), 64'd0);

    // Reset during WAIT, then a late ack must be ignored
    do_reset();
    apply(1'b1, 1'b0, 16'd40, 1'b0, 32'd0, 1'b0);
    step();
    check("rw_req", 64'(bus.MemReq), 64'd1);
    apply(1'b0, 1'b0, 16'd40, 1'b0, 32'd0, 1'b0);
    #1 check("rw_adv_rst", 64'(bus.PcAdvance), 64'd0);
    step();
    check("rw_req_clr", 64'(bus.MemReq), 64'd0);
    check("rw_vld", 64'(bus.InstrValid), 64'd0);
    apply(1'b1, 1'b0, 16'd500, 1'b1, 32'h0000_0BAD, 1'b0);
    step();
    check("rw_late_vld", 64'(bus.InstrValid), 64'd0);
    check("rw_new_addr", 64'(bus.MemAddr), 64'd500);
    apply(1'b1, 1'b0, 16'd500, 1'b0, 32'd0, 1'b0);
    step();
    check("rw_late_vld2", 64'(bus.InstrValid), 64'd0);

    // Flush together with pop on a full queue, then exactly one entry from the next fetch
    do_reset();
    fetch(16'd40, D40, 1'b0);
    fetch(16'd88, D88, 1'b0);
    check("fp_full_pc", 64'(bus.InstrPc), 64'd40);
    apply(1'b1, 1'b1, 16'd200, 1'b0, 32'd0, 1'b1);
    #1 check("fp_adv_full", 64'(bus.PcAdvance), 64'd0);
    step();
    check("fp_vld", 64'(bus.InstrValid), 64'd0);
    fetch(16'd200, D200, 1'b0);
    check("fp_one_vld", 64'(bus.InstrValid), 64'd1);
    check("fp_one_pc", 64'(bus.InstrPc), 64'd200);
    apply(1'b1, 1'b0, 16'd300, 1'b0, 32'd0, 1'b0);
    step();
    apply(1'b1, 1'b0, 16'd300, 1'b0, 32'd0, 1'b1);
    step();
    check("fp_one_only", 64'(bus.InstrValid), 64'd0);

    // Random traffic against the queue model
    do_reset();
    mq.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_addr = 16'd0;
    for (int c = 0; c < 1500; c++) begin
      logic        rst, fl, ack, dr, adv, push, pop;
      logic [15:0] pc;
      logic [31:0] md;
      check("rnd_req", 64'(bus.MemReq), 64'(m_out));
      check("rnd_vld", 64'(bus.InstrValid), 64'(mq.size() != 0));
      if (m_out) check("rnd_addr", 64'(bus.MemAddr), 64'(m_addr));
      if (mq.size() != 0) begin
        check("rnd_ipc", 64'(bus.InstrPc), 64'(mq[0].a));
        check("rnd_ins", 64'(bus.InstrOut), 64'(mq[0].d));
      end
      rst = ($urandom_range(0, 63) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      pc  = 16'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      md  = $urandom;
      dr  = 1'($urandom_range(0, 1));
      apply(rst, fl, pc, ack, md, dr);
      #1;
      adv = rst && !m_out && (mq.size() < 2) && !fl;
      check("rnd_adv", 64'(bus.PcAdvance), 64'(adv));
      if (!rst) begin
        mq.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_addr = 16'd0;
      end else begin
        pop  = (mq.size() != 0) && dr;
        push = 1'b0;
        if (m_out && ack) begin
          push   = !m_drop && !fl;
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else if (m_out && fl) begin
          m_drop = 1'b1;
        end
        if (fl) begin
          mq.delete();
        end else begin
          if (pop) void'(mq.pop_front());
          if (push) mq.push_back('{a: m_addr, d: md});
        end
        if (adv) begin
          m_out  = 1'b1;
          m_addr = pc;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
